gpio_input_conditioner: RTL and testbench
=========================================

// Module: gpio_input_conditioner
// PURPOSE
//  Board-input front end feeding the SoC GPIO input word on the FPGA top.
//  - Synchronises the asynchronous push-buttons (KEY) and slide switches (SW) into the clk domain.
//  - Debounces each bit with its own counter.
//  - Packs the clean bits into the 32-bit GPIO input word.
//  - Emits one-cycle KEY press/release event pulses for top-level glue.
// PARAMETERS
//  W_KEY          4       number of push-buttons; W_KEY+W_SW <= 32
//  W_SW           18      number of slide switches
//  KEY_ACTIVE_LOW 1       1: KEY pin low = pressed (inverted before sync); 0: pin high = pressed
//  SYNC_STAGES    2       synchroniser depth, >= 2
//  DB_CYCLES      500000  stable cycles needed to accept a new level (10 ms @ 50 MHz), >= 2
// PORTS
//  clk            in   1             system clock, single domain
//  reset          in   1             synchronous, active-high reset
//  key_i          in   W_KEY         raw KEY pins, asynchronous
//  sw_i           in   W_SW          raw SW pins, asynchronous
//  gpio_o         out  32            {zeros, key_db[W_KEY-1:0], sw_db[W_SW-1:0]}; key_db 1 = pressed
//  key_press_o    out  W_KEY         1-cycle pulse when key_db bit rises
//  key_release_o  out  W_KEY         1-cycle pulse when key_db bit falls
// BEHAVIOUR
//  - Reset values: all sync flops, debounced bits, counters, gpio_o, key_press_o and key_release_o
//    are 0 after any clock edge with reset=1. Reset 0 on a key means not pressed, after the
//    polarity inversion.
//  - Reset has priority over every other event. Reset mid-count discards partial counts and
//    generates no pulse.
//  - Polarity: when KEY_ACTIVE_LOW=1, the inversion is combinational on key_i, ahead of the
//    first sync flop.
//  - Synchroniser: SYNC_STAGES flops per bit; s = last stage.
//  - Debounce, per bit (db bit, cnt counter of width $clog2(DB_CYCLES)):
//    - s == db: cnt <= 0.
//    - s != db and cnt != DB_CYCLES-1: cnt <= cnt+1.
//    - s != db and cnt == DB_CYCLES-1: db <= s, cnt <= 0.
//    - Any glitch back to db before the threshold restarts the count from 0.
//  - Latency: a clean input step applied before edge 0 appears on gpio_o after edge
//    SYNC_STAGES+DB_CYCLES, exactly. With the defaults this is edge 500002.
//  - Events: key_press_o[i] and key_release_o[i] are registered.
//    - They are 1 in exactly the cycle in which key_db[i] first shows its new value, else 0.
//    - press and release of the same bit are never asserted together.
//  - Simultaneous events: bits are independent. Multiple bits may update on the same edge,
//    and multiple pulses may assert in the same cycle.
//  - Counters never wrap: cnt saturates at DB_CYCLES-1 by construction.
//  - gpio_o[31:W_KEY+W_SW] is constant 0.
//  - gpio_o is driven straight from the debounced flops, with no combinational path from the inputs.
// CONFIGURATION
//  - GPIO_COND_FAST_SIM_EN defined: the effective threshold is 4 cycles for every bit,
//    ignoring DB_CYCLES, so latency = SYNC_STAGES+4. Counter width stays $clog2(DB_CYCLES).
//  - GPIO_COND_FAST_SIM_EN undefined: the threshold is DB_CYCLES as specified above.
//  - Never defined in synthesis builds.
// TESTING (macro undefined; SYNC_STAGES=2, DB_CYCLES=8, KEY_ACTIVE_LOW=1, W_KEY=4, W_SW=18)
//  1. Hold reset 3 cycles, key_i=4'hF, sw_i=0 -> gpio_o=32'h0; press and release pulses 0 throughout.
//  2. sw_i[0] 0->1, held -> gpio_o[0] rises after exactly edge 10; gpio_o is 32'h1 from then on.
//  3. key_i[1]: low 5 cycles, high 2, then low held -> gpio_o[19] rises 10 edges after the last
//     transition; key_press_o=4'b0010 for exactly 1 cycle.
//  4. From state 3, key_i[1] high, held -> gpio_o[19] falls after edge 10; key_release_o=4'b0010
//     for 1 cycle; no press pulse.
//  5. key_i[0] low; reset=1 for 1 cycle at edge 6, then released -> gpio_o[18] stays 0 until
//     10 edges after reset deasserts; exactly 1 press pulse.
//  6. Same cycle: key_i=4'h0 and sw_i=18'h3FFFF -> gpio_o=32'h003FFFFF on a single edge;
//     key_press_o=4'hF for 1 cycle.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// Board KEY/SW front end: synchronise, debounce per bit, pack into the GPIO input word, KEY edge pulses.
// Define GPIO_COND_FAST_SIM_EN to shorten the debounce threshold to 4 cycles (simulation only).
module gpio_input_conditioner #(
  parameter int unsigned W_KEY          = 4,
  parameter int unsigned W_SW           = 18,
  parameter int unsigned KEY_ACTIVE_LOW = 1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DB_CYCLES      = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W_KEY-1:0]  key_i,
  input  logic [W_SW-1:0]   sw_i,
  output logic [31:0]       gpio_o,
  output logic [W_KEY-1:0]  key_press_o,
  output logic [W_KEY-1:0]  key_release_o
);

  localparam int unsigned W_IN = W_KEY + W_SW;
  localparam int unsigned CW   = $clog2(DB_CYCLES);
`ifdef GPIO_COND_FAST_SIM_EN
  localparam int unsigned THRESH = 4;
`else
  localparam int unsigned THRESH = DB_CYCLES;
`endif
  localparam logic [CW-1:0] CNT_MAX = CW'(THRESH - 1);

  logic [W_KEY-1:0] key_lvl;
  logic [W_IN-1:0]  raw;
  logic [W_IN-1:0]  sync_q [SYNC_STAGES];
  logic [W_IN-1:0]  s;
  logic [W_IN-1:0]  db;
  logic [CW-1:0]    cnt [W_IN];
  logic [W_KEY-1:0] key_db;
  logic [W_KEY-1:0] key_shown;

  // Keys are normalised to 1 = pressed before they enter the synchroniser.
  assign key_lvl = (KEY_ACTIVE_LOW != 0) ? ~key_i : key_i;
  assign raw     = {key_lvl, sw_i};
  assign s       = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Per-bit stability counter; any return to the accepted level restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int unsigned b = 0; b < W_IN; b++) cnt[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < W_IN; b++) begin
        if (s[b] == db[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] != CNT_MAX) begin
          cnt[b] <= cnt[b] + CW'(1);
        end else begin
          db[b]  <= s[b];
          cnt[b] <= '0;
        end
      end
    end
  end

  assign key_db    = db[W_IN-1:W_SW];
  assign key_shown = gpio_o[W_IN-1:W_SW];

  // Pulses are aligned with the cycle in which gpio_o first shows the new key level.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_o        <= '0;
      key_press_o   <= '0;
      key_release_o <= '0;
    end else begin
      gpio_o        <= 32'(db);
      key_press_o   <= key_db & ~key_shown;
      key_release_o <= ~key_db & key_shown;
    end
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench for gpio_input_conditioner: window-based reference model, directed cases then random bouncing.
module tb_gpio_input_conditioner;

  localparam int unsigned W_KEY = 4;
  localparam int unsigned W_SW  = 18;
  localparam int unsigned W_IN  = W_KEY + W_SW;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned DB    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [W_KEY-1:0]  key_i = 4'hF;
  logic [W_SW-1:0]   sw_i = '0;
  logic [31:0]       gpio_o;
  logic [W_KEY-1:0]  key_press_o;
  logic [W_KEY-1:0]  key_release_o;

  gpio_input_conditioner #(
    .W_KEY(W_KEY), .W_SW(W_SW), .KEY_ACTIVE_LOW(1), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .key_i(key_i), .sw_i(sw_i),
    .gpio_o(gpio_o), .key_press_o(key_press_o), .key_release_o(key_release_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      gpio;
    logic [W_KEY-1:0] press;
    logic [W_KEY-1:0] rel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a level is accepted once the synchronised input has differed from the
  // accepted level for the last DB consecutive edges; gpio_o shows it one edge later.
  logic [W_IN-1:0] dl[$];
  logic [W_IN-1:0] hist[$];
  logic [W_IN-1:0] db_m;
  logic [31:0]     gpio_m;

  always @(posedge clk) begin
    logic [W_IN-1:0] raw_v;
    logic [W_IN-1:0] s_v;
    exp_t            e;
    bit              all_opp;
    raw_v = {~key_i, sw_i};
    if (reset) begin
      dl = {};
      for (int i = 0; i < SYNC; i++) dl.push_back('0);
      hist = {};
      db_m = '0;
      gpio_m = '0;
      e = '0;
    end else begin
      s_v = dl[SYNC-1];
      e.gpio  = 32'(db_m);
      e.press = db_m[W_IN-1:W_SW] & ~gpio_m[W_IN-1:W_SW];
      e.rel   = ~db_m[W_IN-1:W_SW] & gpio_m[W_IN-1:W_SW];
      gpio_m  = e.gpio;
      hist.push_back(s_v);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
        for (int b = 0; b < W_IN; b++) begin
          all_opp = 1'b1;
          foreach (hist[j]) if (hist[j][b] == db_m[b]) all_opp = 1'b0;
          if (all_opp) db_m[b] = ~db_m[b];
        end
      end
      dl.push_front(raw_v);
      void'(dl.pop_back());
    end
    exp_q.push_back(e);
    model_on = 1'b1;
  end

  // Monitor: one expected response per clock, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (model_on) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_gpio", gpio_o, e.gpio);
        chk("sb_press", 32'(key_press_o), 32'(e.press));
        chk("sb_release", 32'(key_release_o), 32'(e.rel));
        chk("sb_press_and_release", 32'(key_press_o & key_release_o), 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [W_IN-1:0] v;
    int rate;
    // Reset 3 cycles with keys released and switches low.
    step(3);
    chk("reset_gpio", gpio_o, 32'h0);
    chk("reset_press", 32'(key_press_o), 32'h0);
    reset = 1'b0;
    step(2);

    // Switch step: gpio_o[0] rises exactly at edge 10.
    sw_i[0] = 1'b1;
    step(10);
    chk("sw0_before_edge10", 32'(gpio_o[0]), 32'h0);
    step(1);
    chk("sw0_at_edge10", gpio_o, 32'h1);
    step(3);

    // Bouncy key press: low 5, high 2, then held low.
    key_i[1] = 1'b0; step(5);
    key_i[1] = 1'b1; step(2);
    key_i[1] = 1'b0;
    step(10);
    chk("key1_press_early", 32'(gpio_o[19]), 32'h0);
    step(1);
    chk("key1_press_level", 32'(gpio_o[19]), 32'h1);
    chk("key1_press_pulse", 32'(key_press_o), 32'h2);
    step(1);
    chk("key1_press_one_cycle", 32'(key_press_o), 32'h0);
    step(2);

    // Key release.
    key_i[1] = 1'b1;
    step(10);
    chk("key1_release_early", 32'(gpio_o[19]), 32'h1);
    step(1);
    chk("key1_release_level", 32'(gpio_o[19]), 32'h0);
    chk("key1_release_pulse", 32'(key_release_o), 32'h2);
    chk("key1_release_no_press", 32'(key_press_o), 32'h0);
    step(2);

    // Reset mid-count on key 0 restarts the debounce.
    key_i[0] = 1'b0;
    step(6);
    reset = 1'b1; step(1);
    reset = 1'b0;
    step(10);
    chk("key0_after_reset_early", 32'(gpio_o[18]), 32'h0);
    step(1);
    chk("key0_after_reset_level", 32'(gpio_o[18]), 32'h1);
    chk("key0_after_reset_pulse", 32'(key_press_o), 32'h1);
    step(3);

    // All bits change on the same cycle from a clean state.
    reset = 1'b1; key_i = 4'hF; sw_i = '0; step(3);
    reset = 1'b0; step(4);
    key_i = 4'h0; sw_i = 18'h3FFFF;
    step(10);
    chk("all_early", gpio_o, 32'h0);
    step(1);
    chk("all_level", gpio_o, 32'h003FFFFF);
    chk("all_press", 32'(key_press_o), 32'hF);
    step(1);
    chk("all_press_one_cycle", 32'(key_press_o), 32'h0);

    // Random bouncing with occasional resets.
    rate = 4;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) rate = ($urandom_range(1, 0) == 0) ? 3 : 24;
      v = {key_i, sw_i};
      for (int b = 0; b < W_IN; b++)
        if ($urandom_range(rate - 1, 0) == 0) v[b] = ~v[b];
      key_i = v[W_IN-1:W_SW];
      sw_i  = v[W_SW-1:0];
      reset = ($urandom_range(399, 0) == 0);
      step(1);
    end
    reset = 1'b0;
    step(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
